// File: rtl/cut_sched_pkg.sv
// rtl/cut_sched_pkg.sv - shared constants, state codes and request record for cut_field_sched
package cut_sched_pkg;

  localparam int         CUT_W   = 32;
  localparam logic [5:0] LEN_MAX = 6'd32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_MASK  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  typedef struct packed {
    logic [CUT_W-1:0] data;
    logic [4:0]       pos;
    logic [5:0]       len;
    logic             id;
  } cut_req_t;

  function automatic logic [5:0] clamp_len(input logic [5:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

endpackage

// File: rtl/cut_32.sv
// rtl/cut_32.sv - keeps the low n bits of d and clears the rest; n >= 32 passes d through
module cut_32 (
  input  logic [5:0]  n,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] mask;

  always_comb begin
    mask = '0;
    if (n >= 6'd32) mask = '1;
    else            mask = (32'h1 << n[4:0]) - 32'h1;
  end

  assign q = d & mask;

endmodule

// File: rtl/cut_rr_arb.sv
// rtl/cut_rr_arb.sv - two-way round-robin arbiter; pointer names the requester favoured on a tie
module cut_rr_arb
  import cut_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       en,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       ptr
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req_a && (!req_b || ptr == ID_A)) grant = 2'b01;
      else if (req_b)                       grant = 2'b10;
    end
  end

  // After a grant, the other requester gets priority on the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= ID_A;
    else if (accept) ptr <= grant[0] ? ID_B : ID_A;
  end

endmodule

// File: rtl/cut_field_sched.sv
// rtl/cut_field_sched.sv - round-robin scheduler sharing one cut_32 between requesters A and B
// Optional sign fill of the cut field is enabled by defining CUT_SCHED_SIGN_EXT_EN.
module cut_field_sched
  import cut_sched_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [W-1:0] a_data,
  input  logic [4:0]   a_pos,
  input  logic [5:0]   a_len,
  input  logic         a_sext,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [W-1:0] b_data,
  input  logic [4:0]   b_pos,
  input  logic [5:0]   b_len,
  input  logic         b_sext,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_id
);

  logic [1:0]  state;
  cut_req_t    req_q;
  logic [1:0]  grant;
  logic        accept;
  logic        unused_ptr;
  logic [31:0] cut_q;
  logic [31:0] mask_result;

  // Gating with rst_n keeps both readies low for the whole reset.
  cut_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_a  (a_valid),
    .req_b  (b_valid),
    .en     ((state == ST_IDLE) && rst_n),
    .accept (accept),
    .grant  (grant),
    .ptr    (unused_ptr)
  );

  assign a_ready = grant[0];
  assign b_ready = grant[1];
  assign accept  = (a_valid && a_ready) || (b_valid && b_ready);

  cut_32 u_cut (
    .n (req_q.len),
    .d (req_q.data),
    .q (cut_q)
  );

`ifdef CUT_SCHED_SIGN_EXT_EN
  logic        sext_q;
  logic [31:0] fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             sext_q <= 1'b0;
    else if (state == ST_IDLE && accept)    sext_q <= grant[1] ? b_sext : a_sext;
  end

  always_comb begin
    fill = '0;
    if (sext_q && req_q.len != 6'd0 && req_q.len < LEN_MAX && cut_q[req_q.len[4:0] - 5'd1])
      fill = ~((32'h1 << req_q.len[4:0]) - 32'h1);
  end

  assign mask_result = cut_q | fill;
`else
  logic unused_sext;
  assign unused_sext = a_sext ^ b_sext;
  assign mask_result = cut_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= ID_A;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (grant[1]) begin
              req_q.data <= b_data;
              req_q.pos  <= b_pos;
              req_q.len  <= clamp_len(b_len);
              req_q.id   <= ID_B;
            end else begin
              req_q.data <= a_data;
              req_q.pos  <= a_pos;
              req_q.len  <= clamp_len(a_len);
              req_q.id   <= ID_A;
            end
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          req_q.data <= req_q.data >> req_q.pos;
          state      <= ST_MASK;
        end
        ST_MASK: begin
          rsp_data  <= mask_result;
          rsp_id    <= req_q.id;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cut_field_sched.sv
// tb/tb_cut_field_sched.sv - directed table-driven bench for cut_field_sched
module tb_cut_field_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [31:0] a_data, b_data;
  logic [4:0]  a_pos, b_pos;
  logic [5:0]  a_len, b_len;
  logic        a_sext, b_sext;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cut_field_sched #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_pos(a_pos), .a_len(a_len), .a_sext(a_sext),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_pos(b_pos), .b_len(b_len), .b_sext(b_sext),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  typedef struct {
    logic        sel;
    logic [31:0] data;
    logic [4:0]  pos;
    logic [5:0]  len;
    logic        sext;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.sel) begin
      b_valid = 1'b1; b_data = v.data; b_pos = v.pos; b_len = v.len; b_sext = v.sext;
    end else begin
      a_valid = 1'b1; a_data = v.data; a_pos = v.pos; a_len = v.len; a_sext = v.sext;
    end
    #1;
    check("sel_ready", {31'd0, v.sel ? b_ready : a_ready}, 32'd1);
    check("other_ready", {31'd0, v.sel ? a_ready : b_ready}, 32'd0);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    a_data = $urandom; b_data = $urandom; a_pos = 5'd0; b_pos = 5'd0;
    check("lat_shift", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("lat_mask", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("lat_resp", {31'd0, rsp_valid}, 32'd1);
    check("vec_data", rsp_data, v.exp_data);
    check("vec_id", {31'd0, rsp_id}, {31'd0, v.sel});
    tick();
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = '0; b_data = '0; a_pos = '0; b_pos = '0; a_len = '0; b_len = '0; a_sext = 0; b_sext = 0;

    vecs[0] = '{1'b0, 32'hDEADBEEF, 5'd4,  6'd8,  1'b0, 32'h000000EE};
    vecs[1] = '{1'b1, 32'hFFFFFFFF, 5'd28, 6'd8,  1'b0, 32'h0000000F};
    vecs[2] = '{1'b0, 32'hFFFFFFFF, 5'd28, 6'd0,  1'b0, 32'h00000000};
    vecs[3] = '{1'b1, 32'hFFFFFFFF, 5'd0,  6'd40, 1'b0, 32'hFFFFFFFF};
    vecs[4] = '{1'b0, 32'h12345678, 5'd8,  6'd16, 1'b0, 32'h00003456};
    vecs[5] = '{1'b1, 32'h80000000, 5'd31, 6'd63, 1'b0, 32'h00000001};
`ifdef CUT_SCHED_SIGN_EXT_EN
    vecs[6] = '{1'b0, 32'h00000F80, 5'd4,  6'd8,  1'b1, 32'hFFFFFFF8};
    vecs[8] = '{1'b0, 32'h00000070, 5'd4,  6'd3,  1'b1, 32'hFFFFFFFF};
`else
    vecs[6] = '{1'b0, 32'h00000F80, 5'd4,  6'd8,  1'b1, 32'h000000F8};
    vecs[8] = '{1'b0, 32'h00000070, 5'd4,  6'd3,  1'b1, 32'h00000007};
`endif
    vecs[7] = '{1'b0, 32'h00000F80, 5'd4,  6'd8,  1'b0, 32'h000000F8};
    vecs[9] = '{1'b1, 32'h0000A5A5, 5'd0,  6'd32, 1'b1, 32'h0000A5A5};

    // Reset state, with both requesters already asking.
    #12;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("rst_ready", {30'd0, a_ready, b_ready}, 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Simultaneous requests: last table entry was B, so A leads.
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = 32'h000000AA; b_data = 32'h000000BB;
    a_pos = 5'd0; b_pos = 5'd0; a_len = 6'd8; b_len = 6'd8; a_sext = 0; b_sext = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_a_ready", {31'd0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_b_ready", {31'd0, b_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      check("rr_busy_ready", {30'd0, a_ready, b_ready}, 32'd0);
      tick();
      tick();
      check("rr_valid", {31'd0, rsp_valid}, 32'd1);
      check("rr_id", {31'd0, rsp_id}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check("rr_data", rsp_data, (i % 2 == 1) ? 32'h000000BB : 32'h000000AA);
      tick();
    end

    // Backpressure: A wins (last grant B), response held for 5 cycles.
    rsp_ready = 1'b0;
    a_data = 32'hDEADBEEF; a_pos = 5'd4; a_len = 6'd8;
    #1;
    check("bp_a_ready", {31'd0, a_ready}, 32'd1);
    tick();
    a_data = 32'h0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_data", rsp_data, 32'h000000EE);
      check("bp_id", {31'd0, rsp_id}, 32'd0);
      check("bp_ready", {30'd0, a_ready, b_ready}, 32'd0);
      if (i < 4) tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_release_b_ready", {31'd0, b_ready}, 32'd1);
    a_valid = 1'b0; b_valid = 1'b0;
    #1;

    // Request A alone so the pointer favours B, then reset while in MASK.
    a_valid = 1'b1; a_data = 32'hFFFFFFFF; a_pos = 5'd0; a_len = 6'd4;
    tick();
    a_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_ready", {30'd0, a_ready, b_ready}, 32'd0);
    tick();
    tick();
    check("mid_rst_hold_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_hold_ready", {30'd0, a_ready, b_ready}, 32'd0);
    rst_n = 1'b1;
    a_data = 32'h0000_0F0F; b_data = 32'h0000_3333; a_len = 6'd8; b_len = 6'd8;
    #1;
    check("post_rst_a_ready", {31'd0, a_ready}, 32'd1);
    check("post_rst_b_ready", {31'd0, b_ready}, 32'd0);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("post_rst_no_rsp2", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("post_rst_valid", {31'd0, rsp_valid}, 32'd1);
    check("post_rst_id", {31'd0, rsp_id}, 32'd0);
    check("post_rst_data", rsp_data, 32'h0000000F);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
